// File: rtl/direction_write_sequencer.sv
// Sequences border-initialisation and row-major interior writes of an (N+1)x(N+1) direction matrix.
// Optional macro DIR_SEQ_STALL_CNT_EN adds a saturating count of FILL cycles without a valid symbol.
module direction_write_sequencer #(
    parameter int N       = 128,
    parameter int BitAddr = $clog2(N + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               cell_valid,
    input  logic [2:0]         symbol,
    output logic               cell_ready,
    output logic               en_init,
    output logic               hit,
    output logic [BitAddr:0]   addr_init,
    output logic               en_ins,
    output logic [BitAddr:0]   i,
    output logic [BitAddr:0]   j,
    output logic [2:0]         symbol_out,
    output logic               busy,
`ifdef DIR_SEQ_STALL_CNT_EN
    output logic [15:0]        stall_cnt,
`endif
    output logic               done
);

    typedef enum logic [2:0] {IDLE, INIT_ROW, INIT_COL, FILL, DONE} state_t;

    localparam logic [BitAddr:0] ADDR_LAST = (BitAddr + 1)'(N);
    localparam logic [BitAddr:0] IDX_LAST  = (BitAddr + 1)'(N - 1);
    localparam logic [BitAddr:0] ONE       = (BitAddr + 1)'(1);

    state_t           state, state_d;
    logic [BitAddr:0] cnt, cnt_d;
    logic [BitAddr:0] fill_i, fill_i_d;
    logic [BitAddr:0] fill_j, fill_j_d;

    logic             rdy_d, en_init_d, hit_d, en_ins_d, done_d;
    logic [BitAddr:0] addr_d, i_d, j_d;
    logic [2:0]       sym_d;

    // Outputs are computed here for the next cycle and registered below,
    // so every strobe leaves the block together with its index/symbol.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        fill_i_d  = fill_i;
        fill_j_d  = fill_j;
        rdy_d     = 1'b0;
        en_init_d = 1'b0;
        hit_d     = 1'b0;
        addr_d    = '0;
        en_ins_d  = 1'b0;
        i_d       = '0;
        j_d       = '0;
        sym_d     = '0;
        done_d    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_d   = INIT_ROW;
                    cnt_d     = ONE;
                    en_init_d = 1'b1;
                    addr_d    = ONE;
                end
            end
            INIT_ROW: begin
                en_init_d = 1'b1;
                if (cnt == ADDR_LAST) begin
                    state_d = INIT_COL;
                    cnt_d   = ONE;
                    hit_d   = 1'b1;
                    addr_d  = ONE;
                end else begin
                    cnt_d  = cnt + ONE;
                    addr_d = cnt + ONE;
                end
            end
            INIT_COL: begin
                if (cnt == ADDR_LAST) begin
                    state_d  = FILL;
                    cnt_d    = '0;
                    fill_i_d = '0;
                    fill_j_d = '0;
                    rdy_d    = 1'b1;
                end else begin
                    en_init_d = 1'b1;
                    hit_d     = 1'b1;
                    cnt_d     = cnt + ONE;
                    addr_d    = cnt + ONE;
                end
            end
            FILL: begin
                rdy_d = 1'b1;
                if (cell_valid) begin
                    en_ins_d = 1'b1;
                    i_d      = fill_i;
                    j_d      = fill_j;
                    sym_d    = symbol;
                    if (fill_j == IDX_LAST) begin
                        fill_j_d = '0;
                        if (fill_i == IDX_LAST) begin
                            state_d = DONE;
                            rdy_d   = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            fill_i_d = fill_i + ONE;
                        end
                    end else begin
                        fill_j_d = fill_j + ONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over any write or start decided above.
        if (abort && (state != IDLE)) begin
            state_d   = IDLE;
            cnt_d     = '0;
            fill_i_d  = '0;
            fill_j_d  = '0;
            rdy_d     = 1'b0;
            en_init_d = 1'b0;
            hit_d     = 1'b0;
            addr_d    = '0;
            en_ins_d  = 1'b0;
            i_d       = '0;
            j_d       = '0;
            sym_d     = '0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            fill_i     <= '0;
            fill_j     <= '0;
            cell_ready <= 1'b0;
            en_init    <= 1'b0;
            hit        <= 1'b0;
            addr_init  <= '0;
            en_ins     <= 1'b0;
            i          <= '0;
            j          <= '0;
            symbol_out <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            fill_i     <= fill_i_d;
            fill_j     <= fill_j_d;
            cell_ready <= rdy_d;
            en_init    <= en_init_d;
            hit        <= hit_d;
            addr_init  <= addr_d;
            en_ins     <= en_ins_d;
            i          <= i_d;
            j          <= j_d;
            symbol_out <= sym_d;
            busy       <= (state_d != IDLE);
            done       <= done_d;
        end
    end

`ifdef DIR_SEQ_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if ((state == IDLE) && start) begin
            stall_cnt <= '0;
        end else if ((state == FILL) && !cell_valid && !abort && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_direction_write_sequencer.sv
// Randomised and directed bench for direction_write_sequencer (N=4) against a pass-position model.
module tb_direction_write_sequencer;

    localparam int NN = 4;
    localparam int BW = $clog2(NN + 1);
    localparam int AW = BW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          cell_valid = 1'b0;
    logic [2:0]    symbol = 3'b000;
    logic          cell_ready, en_init, hit, en_ins, busy, done;
    logic [BW:0]   addr_init, i, j;
    logic [2:0]    symbol_out;
`ifdef DIR_SEQ_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    direction_write_sequencer #(.N(NN)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .cell_valid (cell_valid),
        .symbol     (symbol),
        .cell_ready (cell_ready),
        .en_init    (en_init),
        .hit        (hit),
        .addr_init  (addr_init),
        .en_ins     (en_ins),
        .i          (i),
        .j          (j),
        .symbol_out (symbol_out),
        .busy       (busy),
`ifdef DIR_SEQ_STALL_CNT_EN
        .stall_cnt  (stall_cnt),
`endif
        .done       (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 border init, 2 interior fill, 3 done.
    // pos counts border writes issued (0..2N-1), k counts interior cells accepted.
    int          phase = 0;
    int          pos = 0;
    int          k = 0;
    int          stall = 0;
    logic        exp_rdy = 0, exp_en_init = 0, exp_hit = 0, exp_en_ins = 0, exp_busy = 0, exp_done = 0;
    logic [BW:0] exp_addr = '0, exp_i = '0, exp_j = '0;
    logic [2:0]  exp_sym = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= 0; pos <= 0; k <= 0; stall <= 0;
            exp_rdy <= 0; exp_en_init <= 0; exp_hit <= 0; exp_addr <= '0;
            exp_en_ins <= 0; exp_i <= '0; exp_j <= '0; exp_sym <= '0;
            exp_busy <= 0; exp_done <= 0;
        end else begin
            exp_rdy <= 0; exp_en_init <= 0; exp_hit <= 0; exp_addr <= '0;
            exp_en_ins <= 0; exp_i <= '0; exp_j <= '0; exp_sym <= '0;
            exp_busy <= 0; exp_done <= 0;
            if ((phase == 1 || phase == 2) && abort) begin
                phase <= 0;
            end else begin
                case (phase)
                    0: if (start) begin
                        phase <= 1; pos <= 0; stall <= 0;
                        exp_en_init <= 1; exp_addr <= AW'(1); exp_busy <= 1;
                    end
                    1: if (pos + 1 < 2 * NN) begin
                        pos <= pos + 1;
                        exp_en_init <= 1;
                        exp_hit <= (pos + 1 >= NN);
                        exp_addr <= AW'((pos + 1) % NN + 1);
                        exp_busy <= 1;
                    end else begin
                        phase <= 2; k <= 0; exp_rdy <= 1; exp_busy <= 1;
                    end
                    2: if (!cell_valid) begin
                        if (stall != 65535) stall <= stall + 1;
                        exp_rdy <= 1; exp_busy <= 1;
                    end else begin
                        exp_en_ins <= 1;
                        exp_i <= AW'(k / NN);
                        exp_j <= AW'(k % NN);
                        exp_sym <= symbol;
                        exp_busy <= 1;
                        if (k == NN * NN - 1) begin
                            phase <= 3; exp_done <= 1;
                        end else begin
                            k <= k + 1; exp_rdy <= 1;
                        end
                    end
                    default: phase <= 0;
                endcase
            end
        end
    end

    int pass_cnt = 0;

    always @(negedge clk) begin
        chk("cell_ready", int'(cell_ready), int'(exp_rdy));
        chk("en_init", int'(en_init), int'(exp_en_init));
        chk("hit", int'(hit), int'(exp_hit));
        chk("addr_init", int'(addr_init), int'(exp_addr));
        chk("en_ins", int'(en_ins), int'(exp_en_ins));
        chk("i", int'(i), int'(exp_i));
        chk("j", int'(j), int'(exp_j));
        chk("symbol_out", int'(symbol_out), int'(exp_sym));
        chk("busy", int'(busy), int'(exp_busy));
        chk("done", int'(done), int'(exp_done));
        chk("strobe_excl", int'(en_init & en_ins), 0);
`ifdef DIR_SEQ_STALL_CNT_EN
        chk("stall_cnt", int'(stall_cnt), stall);
`endif
        if (done) pass_cnt++;
    end

    int q_init[$];
    int q_ins[$];
    int done_cyc;
    int pass_before;

    task automatic run_pass(input int stall_from, input int stall_len,
                            input int abort_cyc, input int extra_start, input int max_cyc);
        q_init.delete();
        q_ins.delete();
        done_cyc = 0;
        @(negedge clk);
        start = 1'b1;
        cell_valid = 1'b1;
        symbol = 3'b001;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            start = (c == extra_start);
            abort = (c == abort_cyc);
            cell_valid = !(c >= stall_from && c < stall_from + stall_len);
            if (en_init) q_init.push_back(int'(hit) * 16 + int'(addr_init));
            if (en_ins) q_ins.push_back(int'(i) * NN + int'(j));
            if (done && done_cyc == 0) done_cyc = c;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    int exp_init[8] = '{1, 2, 3, 4, 17, 18, 19, 20};

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_addr", int'(addr_init), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Uninterrupted pass, with a start pulse while busy that must be ignored.
        pass_before = pass_cnt;
        run_pass(0, 0, 0, 10, 40);
        chk("p1_init_count", q_init.size(), 8);
        for (int n = 0; n < 8 && n < q_init.size(); n++) chk("p1_init_seq", q_init[n], exp_init[n]);
        chk("p1_ins_count", q_ins.size(), 16);
        for (int n = 0; n < q_ins.size(); n++) chk("p1_ins_order", q_ins[n], n);
        chk("p1_done_cycle", done_cyc, 25);
        chk("p1_pass_count", pass_cnt - pass_before, 1);
`ifdef DIR_SEQ_STALL_CNT_EN
        chk("p1_stall_cnt", int'(stall_cnt), 0);
`endif

        // Three-cycle stall while cell (2,1) is pending.
        pass_before = pass_cnt;
        run_pass(18, 3, 0, 0, 40);
        chk("p2_ins_count", q_ins.size(), 16);
        for (int n = 0; n < q_ins.size(); n++) chk("p2_ins_order", q_ins[n], n);
        chk("p2_done_cycle", done_cyc, 28);
        chk("p2_pass_count", pass_cnt - pass_before, 1);
`ifdef DIR_SEQ_STALL_CNT_EN
        chk("p2_stall_cnt", int'(stall_cnt), 3);
`endif

        // Abort while cell (1,2) is presented.
        pass_before = pass_cnt;
        run_pass(0, 0, 15, 0, 40);
        chk("p3_ins_count", q_ins.size(), 6);
        chk("p3_done_cycle", done_cyc, 0);
        chk("p3_pass_count", pass_cnt - pass_before, 0);
        chk("p3_busy", int'(busy), 0);

        // Asynchronous reset during the first-column border writes.
        pass_before = pass_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("p4_in_col", int'(en_init & hit), 1);
        #2 rst = 1'b0;
        #1;
        chk("p4_rst_en_init", int'(en_init), 0);
        chk("p4_rst_addr", int'(addr_init), 0);
        chk("p4_rst_hit", int'(hit), 0);
        chk("p4_rst_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        chk("p4_pass_count", pass_cnt - pass_before, 0);
        chk("p4_idle", int'(busy), 0);

        // Random traffic, all checked against the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start      = ($urandom_range(0, 19) == 0);
            abort      = ($urandom_range(0, 199) == 0);
            cell_valid = ($urandom_range(0, 3) != 0);
            symbol     = 3'($urandom_range(0, 7));
        end
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("rand_completed_passes", int'(pass_cnt > 3), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
